mem_port_arbiter: RTL and testbench

Shares the single read/write port of the JALA data/stack memory between the CPU control sequencer and a host requester (program loader / debug port). Each cycle it picks at most one access and drives the memory port. It returns read data to the winner one cycle later. CPU has priority, with a starvation bound for the host and a host lock for bursts. It sits between the multicycle control unit's memory strobes and the memory; `cpu_stall` tells the control unit to hold its current state.

---
 rtl/jala_mem_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/jala_mem_pkg.sv
// Shared types for the JALA data/stack memory port: arbiter state, owner
// encoding and default bus widths.
package jala_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single JALA memory port between the CPU sequencer and the host
// requester: CPU priority, bounded host starvation, host lock for bursts.
module mem_port_arbiter
    import jala_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              locked
);

    localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    arb_state_t       state;
    arb_state_t       state_nx;
    owner_t           owner;
    logic [CNT_W-1:0] wait_cnt;
    logic             cpu_rd_q;
    logic             host_rd_q;

    // While rst is low nobody is granted, which also zeroes the memory port.
    always_comb begin
        owner = OWN_NONE;
        if (rst) begin
            if (state == ARB_LOCKED) begin
                if (host_req) owner = OWN_HOST;
            end else if (cpu_req && host_req) begin
                owner = (wait_cnt == MAX_CNT) ? OWN_HOST : OWN_CPU;
            end else if (cpu_req) begin
                owner = OWN_CPU;
            end else if (host_req) begin
                owner = OWN_HOST;
            end
        end
    end

    assign cpu_gnt   = (owner == OWN_CPU);
    assign host_gnt  = (owner == OWN_HOST);
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign mem_en    = cpu_gnt | host_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (owner)
            OWN_CPU: begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_HOST: begin
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end
            default: ;
        endcase
    end

    // Lock is only entered on a real host win, so a CPU win with lock held is ignored.
    always_comb begin
        state_nx = state;
        case (state)
            ARB_OPEN:   if (host_gnt && host_lock) state_nx = ARB_LOCKED;
            ARB_LOCKED: if (!host_lock)            state_nx = ARB_OPEN;
            default:    state_nx = ARB_OPEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_OPEN;
            wait_cnt  <= '0;
            cpu_rd_q  <= 1'b0;
            host_rd_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cpu_rd_q  <= cpu_gnt & ~cpu_we;
            host_rd_q <= host_gnt & ~host_we;
            if (host_gnt) begin
                wait_cnt <= '0;
            end else if (host_req && cpu_gnt && (wait_cnt != MAX_CNT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign cpu_rvalid  = cpu_rd_q;
    assign host_rvalid = host_rd_q;
    assign rdata       = mem_rdata;
    assign locked      = (state == ARB_LOCKED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small synchronous
// memory model behind the port.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic        host_req, host_we, host_lock;
    logic [15:0] host_addr, host_wdata;
    logic        host_gnt, host_rvalid;
    logic [15:0] rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        locked;

    logic [15:0] mem [0:255];

    int error_count = 0;
    int check_count = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous read data one cycle after a read strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic creq, input logic cwe, input logic [15:0] caddr,
                                 input logic [15:0] cwdata, input logic hreq, input logic hwe,
                                 input logic [15:0] haddr, input logic [15:0] hwdata,
                                 input logic hlock);
        cpu_req    = creq;
        cpu_we     = cwe;
        cpu_addr   = caddr;
        cpu_wdata  = cwdata;
        host_req   = hreq;
        host_we    = hwe;
        host_addr  = haddr;
        host_wdata = hwdata;
        host_lock  = hlock;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h10] = 16'hBEEF;
        mem[8'h20] = 16'hCAFE;
        mem_rdata  = 16'h0;
        rst = 1'b0;

        // Reset with requests pending: only cpu_stall follows cpu_req.
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b1, 16'h0020, 16'h1111, 1'b1);
        tick();
        tick();
        @(negedge clk);
        checkOutput("rst_cpu_gnt",  32'(cpu_gnt),   32'd0);
        checkOutput("rst_host_gnt", 32'(host_gnt),  32'd0);
        checkOutput("rst_mem_en",   32'(mem_en),    32'd0);
        checkOutput("rst_mem_we",   32'(mem_we),    32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr),  32'd0);
        checkOutput("rst_mem_wd",   32'(mem_wdata), 32'd0);
        checkOutput("rst_stall",    32'(cpu_stall), 32'd1);
        checkOutput("rst_locked",   32'(locked),    32'd0);
        tick();
        rst = 1'b1;
        idle();

        // CPU-only read.
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        checkOutput("t1_cpu_gnt",  32'(cpu_gnt),  32'd1);
        checkOutput("t1_mem_en",   32'(mem_en),   32'd1);
        checkOutput("t1_mem_we",   32'(mem_we),   32'd0);
        checkOutput("t1_mem_addr", 32'(mem_addr), 32'h10);
        tick();
        idle();
        @(negedge clk);
        checkOutput("t1_cpu_rvalid",  32'(cpu_rvalid),  32'd1);
        checkOutput("t1_rdata",       32'(rdata),       32'hBEEF);
        checkOutput("t1_host_rvalid", 32'(host_rvalid), 32'd0);
        tick();

        // Simultaneous writes with lock requested: CPU wins, lock not taken.
        applyStimulus(1'b1, 1'b1, 16'h0040, 16'h1234, 1'b1, 1'b1, 16'h0041, 16'h5678, 1'b1);
        @(negedge clk);
        checkOutput("t6_cpu_gnt",  32'(cpu_gnt),   32'd1);
        checkOutput("t6_host_gnt", 32'(host_gnt),  32'd0);
        checkOutput("t6_mem_we",   32'(mem_we),    32'd1);
        checkOutput("t6_mem_addr", 32'(mem_addr),  32'h40);
        checkOutput("t6_mem_wd",   32'(mem_wdata), 32'h1234);
        checkOutput("t6_stall",    32'(cpu_stall), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0041, 16'h5678, 1'b0);
        @(negedge clk);
        checkOutput("t6_locked",   32'(locked),       32'd0);
        checkOutput("t6_wait_cnt", 32'(dut.wait_cnt), 32'd1);
        checkOutput("t6_host_gnt2",32'(host_gnt),     32'd1);
        checkOutput("t6_mem_addr2",32'(mem_addr),     32'h41);
        checkOutput("t6_mem_wd2",  32'(mem_wdata),    32'h5678);
        tick();
        idle();
        @(negedge clk);
        checkOutput("t6_wait_clr", 32'(dut.wait_cnt), 32'd0);
        checkOutput("t6_no_rv",    32'(cpu_rvalid | host_rvalid), 32'd0);
        tick();

        // Continuous contention: host wins after MAX_WAIT CPU grants.
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t2_cpu_gnt_c%0d", c),  32'(cpu_gnt),   32'(c != 4));
            checkOutput($sformatf("t2_host_gnt_c%0d", c), 32'(host_gnt),  32'(c == 4));
            checkOutput($sformatf("t2_stall_c%0d", c),    32'(cpu_stall), 32'(c == 4));
            checkOutput($sformatf("t2_wait_c%0d", c),     32'(dut.wait_cnt), (c <= 4) ? 32'(c) : 32'd0);
            if (c == 5) begin
                checkOutput("t2_host_rvalid", 32'(host_rvalid), 32'd1);
                checkOutput("t2_host_rdata",  32'(rdata),       32'hCAFE);
            end
            tick();
        end
        idle();
        @(negedge clk);
        checkOutput("t2_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        tick();

        // Host locked burst of writes with CPU waiting.
        for (int c = 0; c < 8; c++) begin
            applyStimulus(c >= 1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b1,
                          16'h0030 + 16'(c), 16'hA000 + 16'(c), c < 6);
            @(negedge clk);
            checkOutput($sformatf("t3_locked_c%0d", c),   32'(locked),   32'(c >= 1 && c <= 6));
            checkOutput($sformatf("t3_cpu_gnt_c%0d", c),  32'(cpu_gnt),  32'(c == 7));
            checkOutput($sformatf("t3_host_gnt_c%0d", c), 32'(host_gnt), 32'(c < 7));
            tick();
        end
        idle();
        @(negedge clk);
        checkOutput("t3_unlocked",   32'(locked),     32'd0);
        checkOutput("t3_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        tick();

        // Interleaved reads: CPU then host, one rvalid at a time.
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        checkOutput("t4_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0035, 16'h0, 1'b0);
        @(negedge clk);
        checkOutput("t4_host_gnt",    32'(host_gnt),    32'd1);
        checkOutput("t4_cpu_rvalid",  32'(cpu_rvalid),  32'd1);
        checkOutput("t4_host_rv_lo",  32'(host_rvalid), 32'd0);
        checkOutput("t4_cpu_rdata",   32'(rdata),       32'hBEEF);
        tick();
        idle();
        @(negedge clk);
        checkOutput("t4_host_rvalid", 32'(host_rvalid), 32'd1);
        checkOutput("t4_cpu_rv_lo",   32'(cpu_rvalid),  32'd0);
        checkOutput("t4_host_rdata",  32'(rdata),       32'hA005);
        tick();

        // Reset in the cycle after a granted CPU read drops the rvalid.
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
        @(negedge clk);
        checkOutput("t5_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_cpu_rvalid", 32'(cpu_rvalid),  32'd0);
        checkOutput("t5_host_rv",    32'(host_rvalid), 32'd0);
        checkOutput("t5_cpu_gnt0",   32'(cpu_gnt),     32'd0);
        checkOutput("t5_host_gnt0",  32'(host_gnt),    32'd0);
        checkOutput("t5_mem_en",     32'(mem_en),      32'd0);
        checkOutput("t5_mem_addr",   32'(mem_addr),    32'd0);
        checkOutput("t5_stall",      32'(cpu_stall),   32'd1);
        checkOutput("t5_wait_rst",   32'(dut.wait_cnt),32'd0);
        tick();
        idle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_rel_rvalid", 32'(cpu_rvalid),    32'd0);
        checkOutput("t5_rel_locked", 32'(locked),        32'd0);
        checkOutput("t5_rel_wait",   32'(dut.wait_cnt),  32'd0);
        tick();
        @(negedge clk);
        checkOutput("t5_late_rvalid", 32'(cpu_rvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
